fsm_dispatch_controller: RTL and testbench
==========================================

// Module: fsm_dispatch_controller
// PURPOSE
// - Sequencer and bus owner in front of the datapath sub-FSMs: unit 0 is the reg-reg ALU FSM, unit 1 is the immediate ALU FSM.
// - Accepts one instruction at a time, decodes the opcode and pulses the selected unit's FSM_start.
// - Muxes the unit's register/latch/ALU/bus enables onto the shared datapath; all other units are held off the bus.
// - Waits for the unit's done, then retires the instruction and counts it.
// PARAMETERS
// - TIMEOUT_CYCLES  64  max cycles in WAIT before abort (valid 2..255; used only with DISPATCH_TIMEOUT_EN)
// PORTS
// - clock            in   1   single clock, rising edge
// - reset            in   1   asynchronous, active-low (0 = reset)
// - instr_valid      in   1   instruction present
// - instr_ready      out  1   high only in IDLE; transfer on valid&&ready
// - instr            in   16  [15:12] opcode, [11:6] param1, [5:0] param2
// - immediate        in   16  sampled with instr
// - opcode           out  4   latched opcode to units
// - param1, param2   out  6   latched params to units
// - immediate_q      out  16  latched immediate to unit 1
// - FSM_start        out  2   one-hot start pulse, bit n = unit n
// - unit_done        in   2   done from each unit
// - unit_abort       out  2   one-cycle abort pulse to the timed-out unit
// - u0_ctrl, u1_ctrl in   15  unit bundles: {bus_register_input_en, bus_register_out_en, register_addr[5:0], latched_bus1_en, latched_bus2_en, alu_bus_out_en, alu_control[3:0]}
// - u1_bus_output    in   16  immediate driven by unit 1
// - bus_register_input_en, bus_register_out_en, latched_bus1_en, latched_bus2_en, alu_bus_out_en  out 1  muxed enables
// - register_addr    out  6   muxed
// - alu_control      out  4   muxed
// - FSM_bus_output   out  16  u1_bus_output when unit 1 selected, else 0
// - instr_done       out  1   one-cycle retire pulse
// - err_timeout      out  1   sticky until reset
// - halted           out  1   sticky until reset
// - instr_count      out  16  retired instructions, wraps 0xFFFF->0
// BEHAVIOUR
// - Reset: state IDLE. All outputs 0 except instr_ready = 1. Latches and counters cleared.
// - Reset mid-operation returns to IDLE immediately and drops all bus enables in the same cycle (asynchronous).
// - Decode:
//   - 0000 = NOP, no unit.
//   - 0001-0111 = unit 0.
//   - 1000-1110 = unit 1.
//   - 1111 = HALT.
// - State IDLE: on valid&&ready, latch instr and immediate.
//   - NOP -> DONE.
//   - HALT -> HALT.
//   - Otherwise -> START.
// - State START (1 cycle): FSM_start[sel] = 1; bus mux follows sel; -> WAIT.
// - State WAIT: bus mux follows sel.
//   - unit_done[sel] = 1 -> DONE.
//   - unit_done of the non-selected unit is ignored.
//   - A done asserted during START is ignored.
// - State DONE (1 cycle): instr_done = 1; instr_count += 1; bus enables 0; -> IDLE.
// - State HALT: instr_ready = 0 and bus enables 0 forever; halted = 1; HALT is not counted.
// - Latency, NOP: accept at T, instr_done at T+1, ready again at T+2.
// - Latency, unit op: FSM_start at T+1; instr_done the cycle after done is seen.
// - Outside START/WAIT every muxed output is 0. This is break-before-make: units never share the bus.
// - Mux outputs are combinational from state and the selected bundle; no added latency.
// CONFIGURATION
// - DISPATCH_TIMEOUT_EN defined:
//   - An 8-bit watchdog clears on entry to WAIT and increments each WAIT cycle.
//   - When it reaches TIMEOUT_CYCLES with no done: unit_abort[sel] pulses, err_timeout sets, -> DONE (instr_done pulses and is counted).
//   - If done and the timeout occur in the same cycle, done wins and no error is raised.
// - DISPATCH_TIMEOUT_EN undefined: WAIT has no bound; unit_abort and err_timeout are tied to 0; no watchdog flops.
// TESTING
// - Reset low mid-WAIT -> all outputs reset in the same cycle, instr_ready = 1, instr_count = 0.
// - instr = 0x1042 (unit 0), done 4 cycles after start:
//   - FSM_start = 2'b01 for 1 cycle.
//   - register_addr/alu_control follow u0_ctrl in START/WAIT only.
//   - instr_done once; instr_count = 1.
// - instr = 0x8040, immediate = 0x00FF, u1_bus_output = 0x00FF:
//   - immediate_q = 0x00FF.
//   - FSM_bus_output = 0x00FF only while unit 1 is selected; u0_ctrl activity is never visible.
// - NOP 0x0000 back-to-back x3 -> instr_done at T+1, T+3, T+5; FSM_start never set.
// - Spurious unit_done[1] during a unit-0 op -> ignored; completes only on unit_done[0].
// - HALT 0xF000 -> halted = 1, instr_ready stays 0; further instr_valid ignored; count unchanged.
// - With DISPATCH_TIMEOUT_EN and TIMEOUT_CYCLES = 8, unit never done:
//   - unit_abort pulses after 8 WAIT cycles.
//   - err_timeout = 1; instr_done pulses.

Source files
------------

// File: rtl/fsm_dispatch_controller_if.sv
// Shared handshake and datapath bundle between the dispatch controller and its environment.
// master = the dispatch controller (bus owner); slave = instruction source, units and datapath.
interface fsm_dispatch_controller_if;
  // Instruction handshake
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] immediate;

  // Latched instruction fields broadcast to the units
  logic [3:0]  opcode;
  logic [5:0]  param1;
  logic [5:0]  param2;
  logic [15:0] immediate_q;

  // Unit control
  logic [1:0]  FSM_start;
  logic [1:0]  unit_done;
  logic [1:0]  unit_abort;

  // Per-unit control bundles and unit 1's bus drive
  logic [14:0] u0_ctrl;
  logic [14:0] u1_ctrl;
  logic [15:0] u1_bus_output;

  // Muxed shared datapath enables
  logic        bus_register_input_en;
  logic        bus_register_out_en;
  logic [5:0]  register_addr;
  logic        latched_bus1_en;
  logic        latched_bus2_en;
  logic        alu_bus_out_en;
  logic [3:0]  alu_control;
  logic [15:0] FSM_bus_output;

  // Status
  logic        instr_done;
  logic        err_timeout;
  logic        halted;
  logic [15:0] instr_count;
  logic [2:0]  state_dbg;

  modport master (
    input  instr_valid,
    input  instr,
    input  immediate,
    input  unit_done,
    input  u0_ctrl,
    input  u1_ctrl,
    input  u1_bus_output,
    output instr_ready,
    output opcode,
    output param1,
    output param2,
    output immediate_q,
    output FSM_start,
    output unit_abort,
    output bus_register_input_en,
    output bus_register_out_en,
    output register_addr,
    output latched_bus1_en,
    output latched_bus2_en,
    output alu_bus_out_en,
    output alu_control,
    output FSM_bus_output,
    output instr_done,
    output err_timeout,
    output halted,
    output instr_count,
    output state_dbg
  );

  modport slave (
    output instr_valid,
    output instr,
    output immediate,
    output unit_done,
    output u0_ctrl,
    output u1_ctrl,
    output u1_bus_output,
    input  instr_ready,
    input  opcode,
    input  param1,
    input  param2,
    input  immediate_q,
    input  FSM_start,
    input  unit_abort,
    input  bus_register_input_en,
    input  bus_register_out_en,
    input  register_addr,
    input  latched_bus1_en,
    input  latched_bus2_en,
    input  alu_bus_out_en,
    input  alu_control,
    input  FSM_bus_output,
    input  instr_done,
    input  err_timeout,
    input  halted,
    input  instr_count,
    input  state_dbg
  );
endinterface

// File: rtl/fsm_dispatch_controller.sv
// Dispatch sequencer: accepts one instruction, starts unit 0 or 1, owns the shared datapath bus.
// Optional watchdog on the WAIT state is enabled by defining DISPATCH_TIMEOUT_EN.
//
// Handshake: an instruction transfers on the rising edge where instr_valid && instr_ready;
// instr_ready is high only in IDLE and instr/immediate are sampled at that edge.
module fsm_dispatch_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic                       clock,
  input logic                       reset,
  fsm_dispatch_controller_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        unit_sel;
  logic [3:0]  opcode_q;
  logic [5:0]  param1_q;
  logic [5:0]  param2_q;
  logic [15:0] immediate_q;
  logic [15:0] count_q;

  logic [3:0]  dec_opcode;
  logic        accept;
  logic        on_bus;
  logic        sel_done;
  logic        timeout_hit;
  logic [14:0] sel_ctrl;
  logic [14:0] bus_ctrl;

  assign dec_opcode = bus.instr[15:12];
  assign accept     = bus.instr_valid && (state == S_IDLE);
  assign sel_done   = bus.unit_done[unit_sel];
  assign on_bus     = (state == S_START) || (state == S_WAIT);

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
`ifdef DISPATCH_TIMEOUT_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wd_count;
  logic [1:0] abort_q;
  logic       err_q;

  // A done in the same cycle as the limit wins, so the hit is qualified by !sel_done.
  assign timeout_hit = (state == S_WAIT) && !sel_done && (wd_count == WD_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_count <= 8'd0;
      abort_q  <= 2'b00;
      err_q    <= 1'b0;
    end else begin
      if (state == S_START) begin
        wd_count <= 8'd0;
      end else if (state == S_WAIT) begin
        wd_count <= wd_count + 8'd1;
      end
      abort_q <= timeout_hit ? (unit_sel ? 2'b10 : 2'b01) : 2'b00;
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.unit_abort  = abort_q;
  assign bus.err_timeout = err_q;
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

  assign timeout_hit     = 1'b0;
  assign bus.unit_abort  = 2'b00;
  assign bus.err_timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (dec_opcode == 4'h0) begin
            state_next = S_DONE;
          end else if (dec_opcode == 4'hF) begin
            state_next = S_HALT;
          end else begin
            state_next = S_START;
          end
        end
      end
      // Done during START is ignored; the unit cannot legitimately finish before it starts.
      S_START: state_next = S_WAIT;
      S_WAIT: begin
        if (sel_done || timeout_hit) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Instruction latch and retire counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      unit_sel    <= 1'b0;
      opcode_q    <= 4'h0;
      param1_q    <= 6'h00;
      param2_q    <= 6'h00;
      immediate_q <= 16'h0000;
      count_q     <= 16'h0000;
    end else begin
      if (accept) begin
        unit_sel    <= dec_opcode[3];
        opcode_q    <= dec_opcode;
        param1_q    <= bus.instr[11:6];
        param2_q    <= bus.instr[5:0];
        immediate_q <= bus.immediate;
      end
      if (state == S_DONE) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bus mux: only the selected unit, and only in START/WAIT (break-before-make)
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_ctrl = unit_sel ? bus.u1_ctrl : bus.u0_ctrl;
    bus_ctrl = on_bus ? sel_ctrl : 15'h0000;
  end

  assign bus.bus_register_input_en = bus_ctrl[14];
  assign bus.bus_register_out_en   = bus_ctrl[13];
  assign bus.register_addr         = bus_ctrl[12:7];
  assign bus.latched_bus1_en       = bus_ctrl[6];
  assign bus.latched_bus2_en       = bus_ctrl[5];
  assign bus.alu_bus_out_en        = bus_ctrl[4];
  assign bus.alu_control           = bus_ctrl[3:0];
  assign bus.FSM_bus_output        = (on_bus && unit_sel) ? bus.u1_bus_output : 16'h0000;

  // ---------------------------------------------------------------------------
  // Status and handshake outputs
  // ---------------------------------------------------------------------------
  assign bus.FSM_start   = (state == S_START) ? (unit_sel ? 2'b10 : 2'b01) : 2'b00;
  assign bus.instr_ready = (state == S_IDLE);
  assign bus.instr_done  = (state == S_DONE);
  assign bus.halted      = (state == S_HALT);
  assign bus.instr_count = count_q;
  assign bus.opcode      = opcode_q;
  assign bus.param1      = param1_q;
  assign bus.param2      = param2_q;
  assign bus.immediate_q = immediate_q;
  assign bus.state_dbg   = state;

endmodule

// File: tb/tb_fsm_dispatch_controller.sv
// Self-checking bench for fsm_dispatch_controller: vector table, corner-case sequences,
// and a retire scoreboard comparing latched instruction fields at each instr_done.
module tb_fsm_dispatch_controller;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  fsm_dispatch_controller_if bus();

  fsm_dispatch_controller #(.TIMEOUT_CYCLES(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] instr;
    logic [15:0] imm;
    logic [14:0] u0c;
    logic [14:0] u1c;
    logic [15:0] u1bus;
    int          dly;
    bit          spur;
    bit          early;
    logic [1:0]  exp_start;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;
  logic [15:0] model_count = 16'h0000;
  vec_t        vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] ctrl_out();
    return {bus.bus_register_input_en, bus.bus_register_out_en, bus.register_addr,
            bus.latched_bus1_en, bus.latched_bus2_en, bus.alu_bus_out_en, bus.alu_control};
  endfunction

  // Retire scoreboard: every instr_done must match the oldest accepted instruction.
  always @(negedge clock) begin
    if (reset && bus.instr_done) begin
      if (exp_q.size() == 0) begin
        check("retire_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("retire_latch", {bus.opcode, bus.param1, bus.param2, bus.immediate_q}, mon_e);
      end
    end
  end

  // Runs one instruction from IDLE; returns at the negedge where the DUT is IDLE again.
  task automatic run_op(input vec_t v);
    logic [14:0] sel_ctrl;
    logic [15:0] sel_bus;
    sel_ctrl = v.exp_start[1] ? v.u1c : v.u0c;
    sel_bus  = v.exp_start[1] ? v.u1bus : 16'h0000;
    bus.u0_ctrl       = v.u0c;
    bus.u1_ctrl       = v.u1c;
    bus.u1_bus_output = v.u1bus;
    check("ready_idle", bus.instr_ready, 1);
    check("ctrl_idle", ctrl_out(), 0);
    check("bus_idle", bus.FSM_bus_output, 0);
    bus.instr       = v.instr;
    bus.immediate   = v.imm;
    bus.instr_valid = 1'b1;
    exp_q.push_back({v.instr, v.imm});
    @(negedge clock);
    bus.instr_valid = 1'b0;
    bus.instr       = 16'($urandom);
    bus.immediate   = 16'($urandom);
    if (v.exp_start == 2'b00) begin
      check("nop_done", bus.instr_done, 1);
      check("nop_start", bus.FSM_start, 0);
      check("nop_ctrl", ctrl_out(), 0);
    end else begin
      check("start_pulse", bus.FSM_start, v.exp_start);
      check("start_ctrl", ctrl_out(), sel_ctrl);
      check("start_bus", bus.FSM_bus_output, sel_bus);
      if (v.early) bus.unit_done = v.exp_start;
      for (int i = 0; i < v.dly; i++) begin
        @(negedge clock);
        bus.unit_done = 2'b00;
        check("wait_start", bus.FSM_start, 0);
        check("wait_ctrl", ctrl_out(), sel_ctrl);
        check("wait_bus", bus.FSM_bus_output, sel_bus);
        check("wait_no_done", bus.instr_done, 0);
        if (v.spur) bus.unit_done = ~v.exp_start;
      end
      bus.unit_done = v.exp_start;
      @(negedge clock);
      bus.unit_done = 2'b00;
      check("retire_pulse", bus.instr_done, 1);
      check("retire_ctrl", ctrl_out(), 0);
      check("retire_bus", bus.FSM_bus_output, 0);
    end
    model_count++;
    @(negedge clock);
    check("idle_done_low", bus.instr_done, 0);
    check("count", bus.instr_count, model_count);
  endtask

  initial begin
    vec_t rv;
    logic [3:0] rop;

    vecs[0] = '{instr:16'h1042, imm:16'h1234, u0c:15'h2ABC, u1c:15'h1555, u1bus:16'hBEEF,
                dly:4, spur:1'b0, early:1'b0, exp_start:2'b01};
    vecs[1] = '{instr:16'h8040, imm:16'h00FF, u0c:15'h7FFF, u1c:15'h0F0F, u1bus:16'h00FF,
                dly:2, spur:1'b0, early:1'b0, exp_start:2'b10};
    vecs[2] = '{instr:16'h0000, imm:16'hA5A5, u0c:15'h7FFF, u1c:15'h7FFF, u1bus:16'hFFFF,
                dly:0, spur:1'b0, early:1'b0, exp_start:2'b00};
    vecs[3] = '{instr:16'h7FFF, imm:16'h0001, u0c:15'h4321, u1c:15'h7FFF, u1bus:16'h5555,
                dly:3, spur:1'b1, early:1'b0, exp_start:2'b01};
    vecs[4] = '{instr:16'hEABC, imm:16'hC0DE, u0c:15'h7FFF, u1c:15'h3C3C, u1bus:16'h8001,
                dly:3, spur:1'b1, early:1'b0, exp_start:2'b10};
    vecs[5] = '{instr:16'h2003, imm:16'h0F0F, u0c:15'h1111, u1c:15'h2222, u1bus:16'h3333,
                dly:1, spur:1'b0, early:1'b1, exp_start:2'b01};

    bus.instr_valid   = 1'b0;
    bus.instr         = 16'h0000;
    bus.immediate     = 16'h0000;
    bus.unit_done     = 2'b00;
    bus.u0_ctrl       = 15'h7FFF;
    bus.u1_ctrl       = 15'h7FFF;
    bus.u1_bus_output = 16'hFFFF;

    // Reset state
    repeat (2) @(negedge clock);
    check("rst_ready", bus.instr_ready, 1);
    check("rst_outputs", {bus.FSM_start, bus.unit_abort, ctrl_out(), bus.FSM_bus_output,
                          bus.instr_done, bus.err_timeout, bus.halted, bus.instr_count}, 0);
    check("rst_latches", {bus.opcode, bus.param1, bus.param2, bus.immediate_q}, 0);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 6; i++) run_op(vecs[i]);

    for (int i = 0; i < 4; i++) begin
      rop = 4'($urandom_range(1, 14));
      rv = '{instr:{rop, 12'($urandom)}, imm:16'($urandom), u0c:15'($urandom),
             u1c:15'($urandom), u1bus:16'($urandom), dly:int'($urandom_range(1, 5)),
             spur:1'($urandom_range(0, 1)), early:1'b0,
             exp_start:(rop >= 4'h8) ? 2'b10 : 2'b01};
      run_op(rv);
    end

    // Three back-to-back NOPs with valid held high
    bus.instr       = 16'h0000;
    bus.immediate   = 16'h0042;
    bus.instr_valid = 1'b1;
    repeat (3) exp_q.push_back({16'h0000, 16'h0042});
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (k == 5) bus.instr_valid = 1'b0;
      check("nop_b2b_done", bus.instr_done, (k % 2 == 1) ? 1 : 0);
      check("nop_b2b_start", bus.FSM_start, 0);
    end
    model_count += 16'd3;
    check("nop_b2b_count", bus.instr_count, model_count);

`ifdef DISPATCH_TIMEOUT_EN
    // Unit 0 never finishes: abort after 8 WAIT cycles, retire counted
    bus.u0_ctrl     = 15'h1234;
    bus.instr       = 16'h3005;
    bus.immediate   = 16'h0007;
    bus.instr_valid = 1'b1;
    exp_q.push_back({16'h3005, 16'h0007});
    @(negedge clock);
    bus.instr_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("to_wait_done", bus.instr_done, 0);
      check("to_wait_abort", bus.unit_abort, 0);
      check("to_wait_err", bus.err_timeout, 0);
    end
    @(negedge clock);
    check("to_abort", bus.unit_abort, 2'b01);
    check("to_err", bus.err_timeout, 1);
    check("to_done", bus.instr_done, 1);
    model_count++;
    @(negedge clock);
    check("to_abort_pulse", bus.unit_abort, 0);
    check("to_err_sticky", bus.err_timeout, 1);
    check("to_count", bus.instr_count, model_count);
`else
    // WAIT is unbounded: a long wait still completes without abort or error
    rv = '{instr:16'h3005, imm:16'h0007, u0c:15'h1234, u1c:15'h7FFF, u1bus:16'hFFFF,
           dly:20, spur:1'b0, early:1'b0, exp_start:2'b01};
    run_op(rv);
    check("long_wait_err", bus.err_timeout, 0);
    check("long_wait_abort", bus.unit_abort, 0);
`endif

    // Reset asserted mid-WAIT takes effect immediately
    bus.u0_ctrl     = 15'h7FFF;
    bus.instr       = 16'h1042;
    bus.immediate   = 16'h0000;
    bus.instr_valid = 1'b1;
    exp_q.push_back({16'h1042, 16'h0000});
    @(negedge clock);
    bus.instr_valid = 1'b0;
    repeat (2) @(negedge clock);
    check("midwait_ctrl", ctrl_out(), 15'h7FFF);
    #2 reset = 1'b0;
    #1;
    check("async_rst_ctrl", ctrl_out(), 0);
    check("async_rst_ready", bus.instr_ready, 1);
    check("async_rst_count", bus.instr_count, 0);
    check("async_rst_start", bus.FSM_start, 0);
    exp_q.delete();
    model_count = 16'h0000;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    run_op(vecs[0]);

    // HALT: sticky, never ready, further instructions ignored and not counted
    bus.instr       = 16'hF000;
    bus.instr_valid = 1'b1;
    @(negedge clock);
    bus.instr = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      check("halt_flag", bus.halted, 1);
      check("halt_ready", bus.instr_ready, 0);
      check("halt_done", bus.instr_done, 0);
      check("halt_ctrl", ctrl_out(), 0);
      @(negedge clock);
    end
    bus.instr_valid = 1'b0;
    check("halt_count", bus.instr_count, model_count);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
